registro_ataques: RTL
=====================

# registro_ataques

Game-state register for the battleship board. Sits between the debounced buttons/layout generator and the LED-matrix scanner: latches the player's ship layout on save, records confirmed attacks, counts hits, detects end of game and produces the five 7-bit column images the matrix multiplexer scans. All logic runs on the 381 Hz divided clock.

## Interface
- N_COLUNAS, 5, board columns.
- N_LINHAS, 7, board rows; bit r of each column image is row r.
- PISCA_DIV, 190, clock cycles per blink-phase toggle (about 1 Hz blink at 381 Hz).
- LED_PULSO, 95, clock cycles the led stays on after a hit.

Ports:
- clock  in  1  divided 381 Hz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ligado  in  1  game power switch; low forces DESLIGADO.
- modo  in  1  0 = posicionamento, 1 = ataque.
- salvar_jogo  in  1  one-cycle debounced pulse; latches layout.
- confirmar_ataque  in  1  one-cycle debounced pulse; fires attack.
- ataque_colunas  in  3  target column, 0..4 valid.
- ataque_linhas  in  3  target row, 0..6 valid.
- coluna1_posicionamento..coluna5_posicionamento  in  7 each  current layout from the layout generator.
- coluna1_saida..coluna5_saida  out  7 each  column images to the matrix scanner.
- led  out  1  hit indicator / game-over indicator.
- acertos  out  6  hits so far (0..35).
- fim_jogo  out  1  all ship cells hit.

## Operation
- Storage: tabuleiro (35 bits, saved layout), atacado (35 bits, cells attacked), total_navios (6 bits, popcount of tabuleiro computed at save), acertos (6 bits).
- States: DESLIGADO, POSICIONAMENTO, ATAQUE, FIM.
- DESLIGADO: outputs zero; atacado and acertos cleared; tabuleiro retained. Exit when ligado=1 to POSICIONAMENTO (modo=0) or ATAQUE (modo=1).
- POSICIONAMENTO: saida = posicionamento inputs. salvar_jogo copies all five columns into tabuleiro, loads total_navios, clears atacado and acertos. modo=1 goes to ATAQUE.
- ATAQUE: on confirmar_ataque with valid coordinates (column ≤ 4, row ≤ 6) and cell not yet in atacado: set atacado bit; if tabuleiro bit set, acertos += 1 and start led pulse. Invalid or repeated target: no state change. salvar_jogo ignored. Display: cell = tabuleiro&atacado steady on; atacado&~tabuleiro on only during blink phase 1; unattacked off. modo=0 returns to POSICIONAMENTO and clears atacado and acertos.
- FIM: entered when total_navios>0 and acertos==total_navios. saida = tabuleiro steady; fim_jogo=1; led=1 steady; attacks ignored. modo=0 goes to POSICIONAMENTO (clears atacado, acertos).
- ligado=0 in any state → DESLIGADO next cycle, overriding every other input.
- total_navios=0: attacks all register as misses; FIM never reached.

## Timing
- Reset: state DESLIGADO, tabuleiro/atacado/acertos/total_navios zero, blink phase 0, led 0, fim_jogo 0, all saida 0.
- All outputs registered; attack pulse in cycle N → atacado, acertos and saida updated at edge N+1, led high from N+1 for LED_PULSO cycles.
- Final hit: acertos reaches total at N+1, state FIM and fim_jogo at N+2.
- Hit during active led pulse restarts the pulse counter.
- Blink counter free-runs 0..PISCA_DIV-1 in ATAQUE, toggles phase on wrap; reset to 0/phase 0 on entry to ATAQUE.
- salvar_jogo and confirmar_ataque in the same cycle: only the one legal in the current state acts.
- acertos cannot exceed 35; no wrap possible since each cell counts once.

## Structure
- Shared package batalha_pkg: state enum (DESLIGADO, POSICIONAMENTO, ATAQUE, FIM), N_COLUNAS, N_LINHAS, board-index function col*N_LINHAS+row.
- One sub-module: divisor_pisca (counter + phase toggle, enable and clear inputs).
- Popcount for total_navios is combinational inside this block.

## Test plan
- Reset then ligado=1, modo=0, layout columns 7'h01,0,0,0,0 → saida mirrors inputs one cycle later; acertos=0, led=0.
- Save layout col1=7'h03 (2 cells), modo=1, attack (0,0) → acertos=1, led high 95 cycles, coluna1_saida bit0 steady 1.
- Attack (0,0) again, then (5,2) and (1,7) → acertos stays 1, atacado unchanged, led not retriggered.
- Attack (2,4) miss → coluna3_saida bit4 toggles every 190 cycles; attack (0,1) → acertos=2, fim_jogo=1 two cycles after pulse, led steady 1.
- Mid-game ligado=0 → all saida 0 next cycle; ligado=1, modo=1 → acertos=0, saved layout intact (hit on (0,0) counts again).
- Assert reset_n low asynchronously during led pulse → led, saida, acertos zero immediately.

Source files
------------

// File: rtl/batalha_pkg.sv
// Shared types and board geometry for the battleship game-state logic.
package batalha_pkg;

    typedef enum logic [1:0] {
        DESLIGADO,
        POSICIONAMENTO,
        ATAQUE,
        FIM
    } estado_t;

    localparam int N_COLUNAS = 5;
    localparam int N_LINHAS  = 7;
    localparam int N_CELULAS = N_COLUNAS * N_LINHAS;

    function automatic logic [5:0] indice(
        input logic [2:0] col,
        input logic [2:0] lin
    );
        return 6'(int'(col) * N_LINHAS + int'(lin));
    endfunction

    function automatic logic [5:0] popcount(
        input logic [N_CELULAS-1:0] v
    );
        logic [5:0] soma;
        soma = '0;
        for (int i = 0; i < N_CELULAS; i++) begin
            soma = soma + 6'(v[i]);
        end
        return soma;
    endfunction

endpackage

// File: rtl/divisor_pisca.sv
// Blink-phase generator: free-running counter toggling a phase bit on wrap.
module divisor_pisca #(
    parameter int DIV = 190
) (
    input  logic clock,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic fase
);

    localparam int W = $clog2(DIV);

    logic [W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            fase <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            fase <= 1'b0;
        end else if (en) begin
            if (cnt == W'(DIV - 1)) begin
                cnt  <= '0;
                fase <= ~fase;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/registro_ataques.sv
// Battleship game state: saved layout, attack record, hit count and
// the registered column images for the LED-matrix scanner.
module registro_ataques
    import batalha_pkg::*;
#(
    parameter int PISCA_DIV = 190,
    parameter int LED_PULSO = 95
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ligado,
    input  logic       modo,
    input  logic       salvar_jogo,
    input  logic       confirmar_ataque,
    input  logic [2:0] ataque_colunas,
    input  logic [2:0] ataque_linhas,
    input  logic [6:0] coluna1_posicionamento,
    input  logic [6:0] coluna2_posicionamento,
    input  logic [6:0] coluna3_posicionamento,
    input  logic [6:0] coluna4_posicionamento,
    input  logic [6:0] coluna5_posicionamento,
    output logic [6:0] coluna1_saida,
    output logic [6:0] coluna2_saida,
    output logic [6:0] coluna3_saida,
    output logic [6:0] coluna4_saida,
    output logic [6:0] coluna5_saida,
    output logic       led,
    output logic [5:0] acertos,
    output logic       fim_jogo
);

    localparam int LW = $clog2(LED_PULSO + 1);

    estado_t              estado, estado_n;
    logic [N_CELULAS-1:0] tabuleiro, tabuleiro_n;
    logic [N_CELULAS-1:0] atacado, atacado_n;
    logic [N_CELULAS-1:0] posic, imagem, imagem_n;
    logic [5:0]           total_navios, total_n;
    logic [5:0]           hits, hits_n;
    logic [LW-1:0]        led_cnt, led_cnt_n;
    logic [5:0]           alvo;
    logic                 valido, novo, acerto, fase;

    assign posic = {
        coluna5_posicionamento,
        coluna4_posicionamento,
        coluna3_posicionamento,
        coluna2_posicionamento,
        coluna1_posicionamento
    };

    assign valido = (ataque_colunas <= 3'(N_COLUNAS - 1)) &&
                    (ataque_linhas <= 3'(N_LINHAS - 1));

    // Out-of-range coordinates are steered to cell 0 and masked by valido.
    assign alvo = valido ? indice(ataque_colunas, ataque_linhas) : 6'd0;
    assign novo = valido && !atacado[alvo];

    always_comb begin
        estado_n    = estado;
        tabuleiro_n = tabuleiro;
        atacado_n   = atacado;
        total_n     = total_navios;
        hits_n      = hits;
        acerto      = 1'b0;
        if (!ligado) begin
            estado_n = DESLIGADO;
        end else begin
            unique case (estado)
                DESLIGADO: begin
                    estado_n = modo ? ATAQUE : POSICIONAMENTO;
                end
                POSICIONAMENTO: begin
                    if (salvar_jogo) begin
                        tabuleiro_n = posic;
                        total_n     = popcount(posic);
                        atacado_n   = '0;
                        hits_n      = '0;
                    end
                    if (modo) estado_n = ATAQUE;
                end
                ATAQUE: begin
                    if (!modo) begin
                        estado_n = POSICIONAMENTO;
                    end else if (total_navios != 6'd0 &&
                                 hits == total_navios) begin
                        estado_n = FIM;
                    end else if (confirmar_ataque && novo) begin
                        atacado_n[alvo] = 1'b1;
                        if (tabuleiro[alvo]) begin
                            hits_n = hits + 6'd1;
                            acerto = 1'b1;
                        end
                    end
                end
                FIM: begin
                    if (!modo) estado_n = POSICIONAMENTO;
                end
            endcase
        end
        if (estado_n == DESLIGADO ||
            (estado_n == POSICIONAMENTO && estado != POSICIONAMENTO)) begin
            atacado_n = '0;
            hits_n    = '0;
        end
    end

    always_comb begin
        imagem_n = '0;
        unique case (estado_n)
            DESLIGADO:      imagem_n = '0;
            POSICIONAMENTO: imagem_n = posic;
            ATAQUE: begin
                imagem_n = (tabuleiro_n & atacado_n) |
                           ({N_CELULAS{fase}} & atacado_n & ~tabuleiro_n);
            end
            FIM:            imagem_n = tabuleiro_n;
        endcase
    end

    always_comb begin
        led_cnt_n = led_cnt;
        if (estado_n == DESLIGADO) begin
            led_cnt_n = '0;
        end else if (acerto) begin
            led_cnt_n = LW'(LED_PULSO);
        end else if (led_cnt != '0) begin
            led_cnt_n = led_cnt - LW'(1);
        end
    end

    divisor_pisca #(
        .DIV (PISCA_DIV)
    ) u_pisca (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (estado == ATAQUE),
        .clr     (estado_n == ATAQUE && estado != ATAQUE),
        .fase    (fase)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado       <= DESLIGADO;
            tabuleiro    <= '0;
            atacado      <= '0;
            total_navios <= '0;
            hits         <= '0;
            led_cnt      <= '0;
            imagem       <= '0;
            led          <= 1'b0;
            fim_jogo     <= 1'b0;
        end else begin
            estado       <= estado_n;
            tabuleiro    <= tabuleiro_n;
            atacado      <= atacado_n;
            total_navios <= total_n;
            hits         <= hits_n;
            led_cnt      <= led_cnt_n;
            imagem       <= imagem_n;
            led          <= (estado_n == FIM) || (led_cnt_n != '0);
            fim_jogo     <= (estado_n == FIM);
        end
    end

    assign coluna1_saida = imagem[0  +: 7];
    assign coluna2_saida = imagem[7  +: 7];
    assign coluna3_saida = imagem[14 +: 7];
    assign coluna4_saida = imagem[21 +: 7];
    assign coluna5_saida = imagem[28 +: 7];
    assign acertos       = hits;

endmodule
